glb_psum_write_arbiter: RTL and testbench

- Shares the single GLB psum write port among Y_dim PE-row psum routers.
- Each row presents a packed row of X_dim psums with a request. Requests are served round-robin.
- The granted row's psums are serialized into X_dim consecutive GLB writes.
- Per-row iteration counters place each row's outputs in a row-interleaved GLB layout.

---
 rtl/glb_psum_write_arbiter.sv | 138 +++++++++++++
 tb/tb_glb_psum_write_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_psum_write_arbiter.sv
// Round-robin arbiter serializing one PE row's X_dim psums onto the GLB write port; grant is
// combinational in IDLE, writes start next cycle, bursts X_dim+1 apart. PSUM_RELU_EN clamps negatives.
module glb_psum_write_arbiter #(
    parameter int DATA_BITWIDTH     = 16,
    parameter int ADDR_BITWIDTH_GLB = 10,
    parameter int X_dim             = 5,
    parameter int Y_dim             = 3,
    parameter int ITER_BITWIDTH     = 8,
    parameter int PSUM_LOAD_ADDR    = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [Y_dim-1:0]                     req_psum,
    input  logic [DATA_BITWIDTH*X_dim*Y_dim-1:0] req_data,
    input  logic                                 pass_clear,
    output logic [Y_dim-1:0]                     grant,
    output logic [ADDR_BITWIDTH_GLB-1:0]         w_addr_glb_psum,
    output logic [DATA_BITWIDTH-1:0]             w_data_glb_psum,
    output logic                                 write_en_glb_psum,
    output logic                                 busy,
    output logic                                 burst_done
);
    localparam int ROW_W = DATA_BITWIDTH * X_dim;
    localparam int GW    = (Y_dim > 1) ? $clog2(Y_dim) : 1;
    localparam int KW    = (X_dim > 1) ? $clog2(X_dim) : 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                       state, state_nxt;
    logic [ITER_BITWIDTH-1:0]     iter [Y_dim];
    logic [GW-1:0]                last_grant, cur_row, win;
    logic                         win_vld, take, do_clear, last_write;
    logic                         clear_pending;
    logic [ROW_W-1:0]             row_hold, row_sel;
    logic [KW-1:0]                k;
    logic [ADDR_BITWIDTH_GLB-1:0] base_calc;

    function automatic logic [DATA_BITWIDTH-1:0] relu(input logic [DATA_BITWIDTH-1:0] w);
`ifdef PSUM_RELU_EN
        return w[DATA_BITWIDTH-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    // Scan from the row after the last winner, wrapping modulo Y_dim.
    always_comb begin
        logic [GW:0] idx;
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int i = 1; i <= Y_dim; i++) begin
            idx = {1'b0, last_grant} + (GW+1)'(i);
            if (idx >= (GW+1)'(Y_dim))
                idx = idx - (GW+1)'(Y_dim);
            if (!win_vld && req_psum[idx[GW-1:0]]) begin
                win     = idx[GW-1:0];
                win_vld = 1'b1;
            end
        end
    end

    assign row_sel   = req_data[int'(win)*ROW_W +: ROW_W];
    assign base_calc = ADDR_BITWIDTH_GLB'(PSUM_LOAD_ADDR
                       + (int'(iter[win]) * Y_dim + int'(win)) * X_dim);
    assign do_clear  = pass_clear || clear_pending;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        take              = 1'b0;
        grant             = '0;
        busy              = 1'b0;
        write_en_glb_psum = 1'b0;
        last_write        = 1'b0;
        burst_done        = 1'b0;
        case (state)
            IDLE: begin
                take = !reset && !do_clear && win_vld;
                if (take) begin
                    grant     = Y_dim'(1) << win;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                busy              = 1'b1;
                write_en_glb_psum = 1'b1;
                last_write        = (k == KW'(X_dim - 1));
                burst_done        = last_write;
                if (last_write)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are loaded one word ahead so w_addr/w_data hold their last value while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < Y_dim; r++) iter[r] <= '0;
            last_grant      <= GW'(Y_dim - 1);
            clear_pending   <= 1'b0;
            cur_row         <= '0;
            row_hold        <= '0;
            k               <= '0;
            w_addr_glb_psum <= ADDR_BITWIDTH_GLB'(PSUM_LOAD_ADDR);
            w_data_glb_psum <= '0;
        end else if (state == IDLE) begin
            if (do_clear) begin
                for (int r = 0; r < Y_dim; r++) iter[r] <= '0;
                last_grant    <= GW'(Y_dim - 1);
                clear_pending <= 1'b0;
            end else if (take) begin
                cur_row         <= win;
                k               <= '0;
                w_addr_glb_psum <= base_calc;
                w_data_glb_psum <= relu(row_sel[DATA_BITWIDTH-1:0]);
                row_hold        <= row_sel >> DATA_BITWIDTH;
            end
        end else begin
            if (pass_clear)
                clear_pending <= 1'b1;
            if (last_write) begin
                iter[cur_row] <= iter[cur_row] + ITER_BITWIDTH'(1);
                last_grant    <= cur_row;
            end else begin
                k               <= k + KW'(1);
                w_addr_glb_psum <= w_addr_glb_psum + ADDR_BITWIDTH_GLB'(1);
                w_data_glb_psum <= relu(row_hold[DATA_BITWIDTH-1:0]);
                row_hold        <= row_hold >> DATA_BITWIDTH;
            end
        end
    end
endmodule

// File: tb/tb_glb_psum_write_arbiter.sv
// Directed bench for glb_psum_write_arbiter with default parameters (X_dim=5, Y_dim=3).
module tb_glb_psum_write_arbiter;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int XD = 5;
    localparam int YD = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic [YD-1:0]      req_psum;
    logic [DW*XD*YD-1:0] req_data;
    logic               pass_clear;
    logic [YD-1:0]      grant;
    logic [AW-1:0]      w_addr_glb_psum;
    logic [DW-1:0]      w_data_glb_psum;
    logic               write_en_glb_psum;
    logic               busy;
    logic               burst_done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    glb_psum_write_arbiter dut (
        .clk(clk), .reset(reset), .req_psum(req_psum), .req_data(req_data),
        .pass_clear(pass_clear), .grant(grant), .w_addr_glb_psum(w_addr_glb_psum),
        .w_data_glb_psum(w_data_glb_psum), .write_en_glb_psum(write_en_glb_psum),
        .busy(busy), .burst_done(burst_done)
    );

    function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] w);
`ifdef PSUM_RELU_EN
        return w[DW-1] ? 16'h0000 : w;
`else
        return w;
`endif
    endfunction

    task automatic set_row(input int r, input logic [DW-1:0] w0, w1, w2, w3, w4);
        req_data[(r*XD+0)*DW +: DW] = w0;
        req_data[(r*XD+1)*DW +: DW] = w1;
        req_data[(r*XD+2)*DW +: DW] = w2;
        req_data[(r*XD+3)*DW +: DW] = w3;
        req_data[(r*XD+4)*DW +: DW] = w4;
    endtask

    task automatic set_row_seq(input int r, input int base);
        for (int k = 0; k < XD; k++) req_data[(r*XD+k)*DW +: DW] = DW'(base + k);
    endtask

    // Samples the current cycle first, then up to max_cyc-1 further cycles.
    task automatic wait_grant(input int max_cyc, output logic [YD-1:0] g);
        g = '0;
        for (int i = 0; i < max_cyc; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (grant != '0) begin
                g = grant;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; pass_clear = 1'b0; req_psum = '0; req_data = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({grant, write_en_glb_psum, busy, burst_done} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000", {grant, write_en_glb_psum, busy, burst_done});
        else n_pass++;
        @(negedge clk); reset = 1'b0; #1;
        n_checks++;
        if (w_addr_glb_psum !== 10'd0) $display("FAIL reset_addr: got %h want 0", w_addr_glb_psum);
        else n_pass++;
        n_checks++;
        if (w_data_glb_psum !== 16'd0) $display("FAIL reset_data: got %h want 0", w_data_glb_psum);
        else n_pass++;
        n_checks++;
        if ({write_en_glb_psum, busy, grant} !== 5'b0)
            $display("FAIL reset_idle: got %b want 00000", {write_en_glb_psum, busy, grant});
        else n_pass++;
    endtask

    task automatic test_single;
        logic [YD-1:0] g;
        logic [31:0] got, exp;
        set_row(0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
        req_psum = 3'b001;
        wait_grant(1, g);
        n_checks++;
        if (g !== 3'b001) $display("FAIL single_grant: got %b want 001", g);
        else n_pass++;
        for (int j = 0; j < XD; j++) begin
            @(negedge clk);
            if (j == 0) req_psum = '0;
            #1;
            got = {write_en_glb_psum, busy, w_addr_glb_psum, w_data_glb_psum, burst_done, grant};
            exp = {1'b1, 1'b1, AW'(j), DW'(j + 1), (j == XD - 1), 3'b000};
            n_checks++;
            if (got !== exp) $display("FAIL single_write%0d: got %h want %h", j, got, exp);
            else n_pass++;
        end
        @(negedge clk); #1;
        got = {3'b0, write_en_glb_psum, busy, burst_done, w_addr_glb_psum, w_data_glb_psum};
        exp = {3'b0, 3'b000, 10'd4, 16'd5};
        n_checks++;
        if (got !== exp) $display("FAIL single_idle_hold: got %h want %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_simultaneous;
        logic [YD-1:0] g;
        logic [31:0] got, exp;
        int t0;
        t0 = 0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        for (int r = 0; r < YD; r++) set_row_seq(r, 256 * (r + 1));
        req_psum = 3'b111;
        for (int i = 0; i < YD; i++) begin
            wait_grant(8, g);
            if (i == 0) t0 = cyc;
            n_checks++;
            if (g !== YD'(1 << i)) $display("FAIL simul_grant%0d: got %b want %b", i, g, YD'(1 << i));
            else n_pass++;
            n_checks++;
            if (cyc - t0 !== 6 * i) $display("FAIL simul_spacing%0d: got %0d want %0d", i, cyc - t0, 6 * i);
            else n_pass++;
            for (int j = 0; j < XD; j++) begin
                @(negedge clk);
                if (j == 0) req_psum[i] = 1'b0;
                #1;
                got = {5'b0, write_en_glb_psum, w_addr_glb_psum, w_data_glb_psum};
                exp = {5'b0, 1'b1, AW'(5 * i + j), exp_word(DW'(256 * (i + 1) + j))};
                n_checks++;
                if (got !== exp) $display("FAIL simul_write%0d_%0d: got %h want %h", i, j, got, exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_iter_layout;
        logic [YD-1:0] g;
        logic [31:0] got, exp;
        @(negedge clk);
        set_row_seq(1, 16'h2000);
        req_psum = 3'b010;
        wait_grant(1, g);
        n_checks++;
        if (g !== 3'b010) $display("FAIL iter_grant: got %b want 010", g);
        else n_pass++;
        for (int j = 0; j < XD; j++) begin
            @(negedge clk);
            if (j == 0) req_psum = '0;
            #1;
            got = {5'b0, write_en_glb_psum, w_addr_glb_psum, w_data_glb_psum};
            exp = {5'b0, 1'b1, AW'(20 + j), DW'(16'h2000 + j)};
            n_checks++;
            if (got !== exp) $display("FAIL iter_write%0d: got %h want %h", j, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_fairness;
        logic [YD-1:0] g;
        logic [YD-1:0] exp_g [4];
        int            exp_b [4];
        exp_g = '{3'b001, 3'b100, 3'b001, 3'b100};
        exp_b = '{0, 10, 15, 25};
        @(negedge clk);
        set_row_seq(0, 16'h3000);
        set_row_seq(2, 16'h3200);
        pass_clear = 1'b1;
        req_psum   = 3'b101;
        #1;
        n_checks++;
        if (grant !== 3'b000) $display("FAIL fair_clear_nogrant: got %b want 000", grant);
        else n_pass++;
        @(negedge clk); pass_clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_grant(8, g);
            n_checks++;
            if (g !== exp_g[i]) $display("FAIL fair_grant%0d: got %b want %b", i, g, exp_g[i]);
            else n_pass++;
            @(negedge clk);
            if (i == 3) req_psum = '0;
            #1;
            n_checks++;
            if ({write_en_glb_psum, w_addr_glb_psum} !== {1'b1, AW'(exp_b[i])})
                $display("FAIL fair_base%0d: got %h want %h", i, {write_en_glb_psum, w_addr_glb_psum}, {1'b1, AW'(exp_b[i])});
            else n_pass++;
            repeat (XD - 1) @(negedge clk);
        end
    endtask

    task automatic test_pass_clear_mid;
        logic [YD-1:0] g;
        logic [31:0] got, exp;
        @(negedge clk);
        set_row_seq(0, 16'h0A00);
        req_psum = 3'b001;
        wait_grant(1, g);
        n_checks++;
        if (g !== 3'b001) $display("FAIL pclr_grant: got %b want 001", g);
        else n_pass++;
        for (int j = 0; j < XD; j++) begin
            @(negedge clk);
            if (j == 0) req_psum = '0;
            if (j == 2) pass_clear = 1'b1;
            if (j == 3) pass_clear = 1'b0;
            if (j == 4) begin
                set_row_seq(0, 16'h0B00);
                req_psum = 3'b101;
            end
            #1;
            got = {4'b0, write_en_glb_psum, burst_done, w_addr_glb_psum, w_data_glb_psum};
            exp = {4'b0, 1'b1, (j == XD - 1), AW'(30 + j), DW'(16'h0A00 + j)};
            n_checks++;
            if (got !== exp) $display("FAIL pclr_write%0d: got %h want %h", j, got, exp);
            else n_pass++;
        end
        @(negedge clk); #1;
        n_checks++;
        if ({grant, write_en_glb_psum} !== 4'b0)
            $display("FAIL pclr_clear_cycle: got %b want 0000", {grant, write_en_glb_psum});
        else n_pass++;
        @(negedge clk);
        wait_grant(1, g);
        n_checks++;
        if (g !== 3'b001) $display("FAIL pclr_regrant: got %b want 001", g);
        else n_pass++;
        for (int j = 0; j < XD; j++) begin
            @(negedge clk);
            if (j == 0) req_psum = '0;
            #1;
            got = {5'b0, write_en_glb_psum, w_addr_glb_psum, w_data_glb_psum};
            exp = {5'b0, 1'b1, AW'(j), DW'(16'h0B00 + j)};
            n_checks++;
            if (got !== exp) $display("FAIL pclr_rewrite%0d: got %h want %h", j, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        logic [YD-1:0] g;
        logic [31:0] got, exp;
        @(negedge clk);
        set_row_seq(0, 16'h0C00);
        set_row_seq(1, 16'h0D00);
        req_psum = 3'b001;
        wait_grant(1, g);
        n_checks++;
        if (g !== 3'b001) $display("FAIL rmid_grant: got %b want 001", g);
        else n_pass++;
        @(negedge clk); req_psum = '0; #1;
        n_checks++;
        if ({write_en_glb_psum, w_addr_glb_psum} !== {1'b1, 10'd15})
            $display("FAIL rmid_base: got %h want %h", {write_en_glb_psum, w_addr_glb_psum}, {1'b1, 10'd15});
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (w_addr_glb_psum !== 10'd16) $display("FAIL rmid_addr1: got %h want 010", w_addr_glb_psum);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk); #1;
        got = {2'b0, write_en_glb_psum, busy, grant, w_addr_glb_psum, w_data_glb_psum};
        exp = 32'h0;
        n_checks++;
        if (got !== exp) $display("FAIL rmid_after_reset: got %h want %h", got, exp);
        else n_pass++;
        reset = 1'b0;
        req_psum = 3'b011;
        wait_grant(1, g);
        n_checks++;
        if (g !== 3'b001) $display("FAIL rmid_rr_reset: got %b want 001", g);
        else n_pass++;
        for (int j = 0; j < XD; j++) begin
            @(negedge clk);
            if (j == 0) req_psum = 3'b010;
            #1;
            got = {5'b0, write_en_glb_psum, w_addr_glb_psum, w_data_glb_psum};
            exp = {5'b0, 1'b1, AW'(j), DW'(16'h0C00 + j)};
            n_checks++;
            if (got !== exp) $display("FAIL rmid_write%0d: got %h want %h", j, got, exp);
            else n_pass++;
        end
        wait_grant(3, g);
        n_checks++;
        if (g !== 3'b010) $display("FAIL rmid_row1_grant: got %b want 010", g);
        else n_pass++;
        @(negedge clk); req_psum = '0; #1;
        n_checks++;
        if ({write_en_glb_psum, w_addr_glb_psum} !== {1'b1, 10'd5})
            $display("FAIL rmid_row1_base: got %h want %h", {write_en_glb_psum, w_addr_glb_psum}, {1'b1, 10'd5});
        else n_pass++;
        repeat (XD - 1) @(negedge clk);
    endtask

    task automatic test_relu;
        logic [YD-1:0] g;
        logic [DW-1:0] words [XD];
        logic [31:0] got, exp;
        words = '{16'hFFF0, 16'h0007, 16'h8000, 16'h7FFF, 16'h0000};
        @(negedge clk);
        set_row(2, words[0], words[1], words[2], words[3], words[4]);
        req_psum = 3'b100;
        wait_grant(1, g);
        n_checks++;
        if (g !== 3'b100) $display("FAIL relu_grant: got %b want 100", g);
        else n_pass++;
        for (int j = 0; j < XD; j++) begin
            @(negedge clk);
            if (j == 0) req_psum = '0;
            #1;
            got = {5'b0, write_en_glb_psum, w_addr_glb_psum, w_data_glb_psum};
            exp = {5'b0, 1'b1, AW'(10 + j), exp_word(words[j])};
            n_checks++;
            if (got !== exp) $display("FAIL relu_write%0d: got %h want %h", j, got, exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_simultaneous;
        test_iter_layout;
        test_fairness;
        test_pass_clear_mid;
        test_reset_mid;
        test_relu;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
